// File: rtl/axi_stream_out_arbiter_pkg.sv
// Shared types and sizing for the output-side stream arbiter.
// Pure declarations, no logic.
package axi_stream_out_arbiter_pkg;

    localparam int NUM_OUT_SRC  = 4;
    localparam int OUT_SRC_ID_W = $clog2(NUM_OUT_SRC);
    localparam int TILE_CNT_W   = 16;
    localparam int OUT_DATA_W   = 64;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_STREAM = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axi_stream_out_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, cyclically.
// Latency: combinational.
// Backpressure: none, pure function of req/ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!grant_vld && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_out_arbiter.sv
// Tile-granular round-robin mux of NUM_SRC streams onto one AXI-Stream output.
// Latency: one arbitration cycle per tile, then zero-latency combinational passthrough.
// Backpressure: out_ready routed straight to the granted source; other sources held off.
module axi_stream_out_arbiter
    import axi_stream_out_arbiter_pkg::*;
#(
    parameter int NUM_SRC = NUM_OUT_SRC,
    parameter int DATA_W  = OUT_DATA_W,
    parameter int CNT_W   = TILE_CNT_W,
    localparam int ID_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          cfg_tile_beats,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_last,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           out_src_id,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      len_err,
    input  logic                      err_clear
);

    arb_state_t         state, state_nxt;
    logic [NUM_SRC-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   tile_len;

    logic [NUM_SRC-1:0] arb_oh;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_vld;

    logic sel_last;
    logic end_cnt;
    logic hs;
    logic fin;

    rr_arbiter #(.N(NUM_SRC), .IDX_W(ID_W)) u_rr (
        .req       (src_valid),
        .ptr       (rr_ptr),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign end_cnt    = (beat_cnt == tile_len - CNT_W'(1));
    assign hs         = out_valid & out_ready;
    assign fin        = hs & out_last;
    assign busy       = (state == ARB_STREAM);
    assign out_src_id = gnt_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (arb_vld) state_nxt = ARB_STREAM;
            ARB_STREAM: if (fin)     state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // AND-OR mux on the registered one-hot grant keeps the data path shallow.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        src_ready = '0;
        sel_last  = 1'b0;
        if (state == ARB_STREAM) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt_oh[i]) begin
                    out_data = out_data | src_data[i*DATA_W +: DATA_W];
                end
            end
            out_valid = |(src_valid & gnt_oh);
            sel_last  = |(src_last & gnt_oh);
            src_ready = gnt_oh & {NUM_SRC{out_ready}};
            out_last  = out_valid & (sel_last | end_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_oh    <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            tile_len  <= CNT_W'(1);
            tile_done <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            tile_done <= fin;
            if (state == ARB_IDLE && arb_vld) begin
                gnt_oh   <= arb_oh;
                gnt_idx  <= arb_idx;
                beat_cnt <= '0;
                tile_len <= (cfg_tile_beats == '0) ? CNT_W'(1) : cfg_tile_beats;
            end else if (fin) begin
                beat_cnt <= '0;
                rr_ptr   <= (gnt_idx == ID_W'(NUM_SRC - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else if (hs) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            // A fresh mismatch wins over a same-cycle clear.
            if (fin && (sel_last != end_cnt)) begin
                len_err <= 1'b1;
            end else if (err_clear) begin
                len_err <= 1'b0;
            end
        end
    end

endmodule
